// File: rtl/md_issue_ctrl.sv
// Issue/sequencing control for the multiply/divide unit: accepts mult/div ops from E,
// counts the execute latency, strobes the HI/LO commit, and stalls D while the unit is busy.
module md_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_valid,
    input  logic [3:0] e_op,
    input  logic       req,
    input  logic       d_md_use,
    output logic       md_start,
    output logic [3:0] md_ctrl,
    output logic       md_commit,
    output logic       busy,
    output logic       stall_d,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMMIT
    } state_e;

    localparam logic [3:0] MULT_LAT_C = 4'(MULT_LAT);
    localparam logic [3:0] DIV_LAT_C  = 4'(DIV_LAT);
    localparam logic [3:0] CTRL_NOP   = 4'b1111;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] lat_q, lat_d;
    logic       err_q, err_d;

    logic start_op;
    logic move_to;
    logic accept;

    assign start_op = (e_op[3:2] == 2'b00);
    assign move_to  = (e_op == 4'd6) || (e_op == 4'd7);
    // A start op is never taken in a reset cycle, even though the register reset wins anyway.
    assign accept   = e_valid && start_op && !req && (state_q == IDLE) && !reset;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        err_d     = err_q;
        md_start  = accept;
        md_commit = 1'b0;
        md_ctrl   = CTRL_NOP;

        // mfhi/mflo still read HI/LO under an exception request; everything else is squashed.
        if (e_valid && !e_op[3] && (!req || e_op == 4'd4 || e_op == 4'd5)) begin
            md_ctrl = e_op;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = 4'd1;
                    lat_d   = e_op[1] ? DIV_LAT_C : MULT_LAT_C;
                end
            end
            RUN: begin
                if (cnt_q < lat_q) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                md_commit = 1'b1;
                state_d   = IDLE;
                cnt_d     = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (e_valid && e_op[3]) begin
            err_d = 1'b1;
        end
        if (e_valid && (state_q != IDLE) && (start_op || move_to)) begin
            err_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments; reset here is synchronous and active-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            lat_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
        end
    end

    assign busy    = md_start || (state_q != IDLE);
    assign stall_d = d_md_use && busy;
    assign err     = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: direct output checks plus a commit-time scoreboard
// for a default-latency instance and a boundary-latency (1 / 15) instance.
module tb_md_issue_ctrl;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       e_valid  = 1'b0;
    logic [3:0] e_op     = 4'd0;
    logic       req      = 1'b0;
    logic       d_md_use = 1'b0;
    logic       md_start, md_commit, busy, stall_d, err;
    logic [3:0] md_ctrl;

    logic       e_valid2 = 1'b0;
    logic [3:0] e_op2    = 4'd0;
    logic       md_start2, md_commit2, busy2, stall_d2, err2;
    logic [3:0] md_ctrl2;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int q1[$];
    int q2[$];
    bit mon_en = 1'b0;
    int t0;

    md_issue_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .e_valid  (e_valid),
        .e_op     (e_op),
        .req      (req),
        .d_md_use (d_md_use),
        .md_start (md_start),
        .md_ctrl  (md_ctrl),
        .md_commit(md_commit),
        .busy     (busy),
        .stall_d  (stall_d),
        .err      (err)
    );

    md_issue_ctrl #(.MULT_LAT(1), .DIV_LAT(15)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .e_valid  (e_valid2),
        .e_op     (e_op2),
        .req      (1'b0),
        .d_md_use (1'b0),
        .md_start (md_start2),
        .md_ctrl  (md_ctrl2),
        .md_commit(md_commit2),
        .busy     (busy2),
        .stall_d  (stall_d2),
        .err      (err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic go(input logic v, input logic [3:0] op, input logic r, input logic u,
                      input logic rst = 1'b0);
        @(posedge clk);
        #1;
        reset    = rst;
        e_valid  = v;
        e_op     = op;
        req      = r;
        d_md_use = u;
        @(negedge clk);
    endtask

    task automatic go2(input logic v, input logic [3:0] op);
        @(posedge clk);
        #1;
        e_valid2 = v;
        e_op2    = op;
        @(negedge clk);
    endtask

    // Commit scoreboards: expected commit cycles are pushed when an op is accepted.
    always @(negedge clk) begin
        if (mon_en) begin
            if (md_commit === 1'b1) begin
                if (q1.size() == 0) check("commit1_unexpected", 1, 0);
                else                check("commit1_cycle", cyc, q1.pop_front());
            end else if (q1.size() != 0 && q1[0] < cyc) begin
                check("commit1_missing", cyc, q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (md_commit2 === 1'b1) begin
                if (q2.size() == 0) check("commit2_unexpected", 1, 0);
                else                check("commit2_cycle", cyc, q2.pop_front());
            end else if (q2.size() != 0 && q2[0] < cyc) begin
                check("commit2_missing", cyc, q2.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin
        // Reset with a mult presented: must not be accepted
        go(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        check("rst_no_start", md_start, 0);
        check("rst_not_busy", busy, 0);
        go(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        go(1'b0, 4'd0, 1'b0, 1'b0);
        check("post_rst_start", md_start, 0);
        check("post_rst_ctrl", md_ctrl, 4'hF);
        check("post_rst_commit", md_commit, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_stall", stall_d, 0);
        check("post_rst_err", err, 0);
        mon_en = 1'b1;

        // mult with default latency: busy T..T+6, commit T+6
        go(1'b1, 4'd0, 1'b0, 1'b0);
        t0 = cyc;
        check("mult_start", md_start, 1);
        check("mult_ctrl", md_ctrl, 4'd0);
        check("mult_busy0", busy, 1);
        q1.push_back(t0 + 6);
        for (int i = 1; i <= 7; i++) begin
            go(1'b0, 4'd0, 1'b0, 1'b0);
            check("mult_busy", busy, (i <= 6));
        end

        // divu with D-stage MD use: stall T..T+11
        go(1'b1, 4'd3, 1'b0, 1'b1);
        t0 = cyc;
        check("divu_stall0", stall_d, 1);
        q1.push_back(t0 + 11);
        for (int i = 1; i <= 12; i++) begin
            go(1'b0, 4'd0, 1'b0, 1'b1);
            check("divu_stall", stall_d, (i <= 11));
        end

        // div blocked by req, then accepted; illegal issues during RUN
        go(1'b1, 4'd2, 1'b1, 1'b0);
        check("div_req_start", md_start, 0);
        check("div_req_ctrl", md_ctrl, 4'hF);
        check("div_req_busy", busy, 0);
        go(1'b1, 4'd2, 1'b0, 1'b0);
        t0 = cyc;
        check("div_start", md_start, 1);
        check("div_ctrl", md_ctrl, 4'd2);
        q1.push_back(t0 + 11);
        for (int i = 1; i <= 11; i++) begin
            case (i)
                2: begin
                    go(1'b1, 4'd1, 1'b0, 1'b0);
                    check("run_multu_start", md_start, 0);
                    check("run_multu_ctrl", md_ctrl, 4'd1);
                end
                4: begin
                    go(1'b1, 4'd6, 1'b0, 1'b0);
                    check("run_mthi_ctrl", md_ctrl, 4'd6);
                end
                5: begin
                    go(1'b1, 4'd4, 1'b1, 1'b0);
                    check("run_mfhi_req_ctrl", md_ctrl, 4'd4);
                end
                default: go(1'b0, 4'd0, 1'b0, 1'b0);
            endcase
            check("err_sticky", err, (i >= 3));
        end
        go(1'b0, 4'd0, 1'b0, 1'b0);
        check("div_done_busy", busy, 0);
        check("err_held", err, 1);

        go(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        go(1'b0, 4'd0, 1'b0, 1'b0);
        check("err_cleared", err, 0);

        // Reserved opcode in IDLE
        go(1'b1, 4'd9, 1'b0, 1'b0);
        check("rsv_ctrl", md_ctrl, 4'hF);
        check("rsv_start", md_start, 0);
        check("rsv_busy", busy, 0);
        go(1'b0, 4'd0, 1'b0, 1'b0);
        check("rsv_err", err, 1);
        check("rsv_idle", busy, 0);
        go(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // mult with req raised at cnt=3: no abort
        go(1'b1, 4'd0, 1'b0, 1'b0);
        t0 = cyc;
        check("mult2_start", md_start, 1);
        q1.push_back(t0 + 6);
        for (int i = 1; i <= 7; i++) go(1'b0, 4'd0, (i == 3 || i == 4), 1'b0);
        check("mult2_err", err, 0);

        // div abandoned by reset at cnt=4
        go(1'b1, 4'd2, 1'b0, 1'b0);
        t0 = cyc;
        q1.push_back(t0 + 11);
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) begin
                go(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
                q1.delete();
            end else begin
                go(1'b0, 4'd0, 1'b0, 1'b0);
            end
            if (i == 5) begin
                check("abort_busy", busy, 0);
                check("abort_err", err, 0);
            end
        end

        // Back-to-back: new op taken the cycle after COMMIT
        go(1'b1, 4'd0, 1'b0, 1'b0);
        t0 = cyc;
        q1.push_back(t0 + 6);
        for (int i = 1; i <= 6; i++) go(1'b0, 4'd0, 1'b0, 1'b0);
        go(1'b1, 4'd1, 1'b0, 1'b0);
        check("b2b_start", md_start, 1);
        q1.push_back(cyc + 6);
        for (int i = 1; i <= 7; i++) go(1'b0, 4'd0, 1'b0, 1'b0);
        check("b2b_err", err, 0);

        // Boundary latencies on the second instance: 1 and 15
        go2(1'b1, 4'd0);
        check("lat1_start", md_start2, 1);
        check("lat1_ctrl", md_ctrl2, 4'd0);
        q2.push_back(cyc + 2);
        go2(1'b0, 4'd0);
        check("lat1_busy", busy2, 1);
        go2(1'b0, 4'd0);
        go2(1'b1, 4'd3);
        check("lat15_start", md_start2, 1);
        q2.push_back(cyc + 16);
        for (int i = 1; i <= 17; i++) go2(1'b0, 4'd0);
        check("lat15_idle", busy2, 0);
        check("lat_err2", err2, 0);
        check("lat_stall2", stall_d2, 0);

        go(1'b0, 4'd0, 1'b0, 1'b0);
        go(1'b0, 4'd0, 1'b0, 1'b0);
        check("sb1_drained", q1.size(), 0);
        check("sb2_drained", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
